// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package ifetch_pkg;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC000000;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry shifting FIFO of fetch entries; flush wins over push, head holds when empty.
module ifetch_skid_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t mem0_q, mem0_d;
    fetch_entry_t mem1_q, mem1_d;
    logic         do_pop, do_push;

    always_comb begin
        count_d = count_q;
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && !flush && ((count_q < 2'd2) || do_pop);

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) mem0_d = push_data;
                    else                 mem1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists so an empty head keeps its last value.
                    if (count_q == 2'd2) mem0_d = mem1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        mem0_d = mem1_q;
                        mem1_d = push_data;
                    end else begin
                        mem0_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            mem0_q  <= '0;
            mem1_q  <= '0;
        end else begin
            count_q <= count_d;
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
        end
    end

    assign count = count_q;
    assign head  = mem0_q;

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch controller: PC, RUN/HALT FSM, redirect/flush and a 2-entry output buffer.
// Define IFETCH_PERF_EN to add saturating fetch_cnt / stall_cnt performance counters.
module ifetch_sequencer
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = 6,
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              halted
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    logic [31:0]  pc_q, pc_d;
    state_e       state_q, state_d;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_data;
    logic         push, pop, is_halt;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == StRun) && !redirect_valid && ((count < 2'd2) || pop);
    assign is_halt   = (rom_dout == HALT_WORD);
    assign rom_addr  = pc_q[ADDR_W+1:2];
    assign push_data = '{pc: pc_q, instr: rom_dout};
    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign halted    = (state_q == StHalt);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'h3;
            state_d = StRun;
        end else if (push) begin
            // The halt word is buffered but the PC stays on it.
            if (is_halt) state_d = StHalt;
            else         pc_d    = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= StRun;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    ifetch_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .count     (count),
        .head      (head)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (push && (fetch_cnt_q != 32'hFFFFFFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFFFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
